// File: rtl/program_loader_if.sv
// Byte-stream handshake and program-memory write port shared by the loader and its environment.
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;

  modport master (
    output ByteIn,
    output ByteValid,
    input  ByteReady,
    input  MemWrite,
    input  MemAddress,
    input  MemWriteData
  );

  modport slave (
    input  ByteIn,
    input  ByteValid,
    output ByteReady,
    output MemWrite,
    output MemAddress,
    output MemWriteData
  );
endinterface

// File: rtl/program_loader.sv
// Loads a framed, XOR-checksummed byte stream into program memory as big-endian 32-bit words,
// holding the CPU until a good frame has been written.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  program_loader_if.slave   bus,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

  state_e                state_r, next_state_s;
  logic                  ready_r, hold_r, done_r, error_r;
  logic                  ready_s, hold_s, done_s, error_s;
  logic [7:0]            xor_r, len_hi_r;
  logic [15:0]           len_r, cnt_r, len_s;
  logic [1:0]            lane_r;
  logic [23:0]           word_r;
  logic                  wr_r;
  logic [DATA_WIDTH-1:0] addr_r, data_r;
  logic                  xfer_s, open_s, last_byte_s;

  function automatic logic [7:0] xor_accumulate(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign xfer_s      = bus.ByteValid && ready_r;
  assign open_s      = Start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));
  assign len_s       = {len_hi_r, bus.ByteIn};
  assign last_byte_s = (lane_r == 2'd3) && (cnt_r == (len_r - 16'd1));

  // State and status output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      hold_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= ready_s;
      hold_r  <= hold_s;
      done_r  <= done_s;
      error_r <= error_s;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (Start) next_state_s = LEN_HI;
        else       next_state_s = state_r;
      end
      LEN_HI: begin
        if (xfer_s) next_state_s = LEN_LO;
        else        next_state_s = state_r;
      end
      LEN_LO: begin
        if (!xfer_s)                next_state_s = state_r;
        else if (len_s > DEPTH_W)   next_state_s = ERROR;
        else if (len_s == 16'd0)    next_state_s = CHECK;
        else                        next_state_s = DATA;
      end
      DATA: begin
        if (xfer_s && last_byte_s) next_state_s = CHECK;
        else                       next_state_s = state_r;
      end
      CHECK: begin
        if (!xfer_s)                   next_state_s = state_r;
        else if (bus.ByteIn == xor_r)  next_state_s = DONE;
        else                           next_state_s = ERROR;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Status decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    ready_s = 1'b0;
    hold_s  = 1'b0;
    done_s  = 1'b0;
    error_s = 1'b0;
    case (next_state_s)
      LEN_HI, LEN_LO, DATA, CHECK: begin
        ready_s = 1'b1;
        hold_s  = 1'b1;
      end
      DONE:  done_s = 1'b1;
      ERROR: begin
        hold_s  = 1'b1;
        error_s = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
        hold_s  = 1'b0;
      end
    endcase
  end

  // Length capture, running XOR, word assembly and memory write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_r    <= 8'd0;
      len_hi_r <= 8'd0;
      len_r    <= 16'd0;
      cnt_r    <= 16'd0;
      lane_r   <= 2'd0;
      word_r   <= 24'd0;
      wr_r     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
    end else begin
      wr_r <= 1'b0;
      if (open_s) begin
        xor_r    <= 8'd0;
        len_hi_r <= 8'd0;
        len_r    <= 16'd0;
        cnt_r    <= 16'd0;
        lane_r   <= 2'd0;
        word_r   <= 24'd0;
      end else if (xfer_s) begin
        case (state_r)
          LEN_HI: begin
            len_hi_r <= bus.ByteIn;
            xor_r    <= xor_accumulate(xor_r, bus.ByteIn);
          end
          LEN_LO: begin
            len_r <= len_s;
            xor_r <= xor_accumulate(xor_r, bus.ByteIn);
          end
          DATA: begin
            xor_r <= xor_accumulate(xor_r, bus.ByteIn);
            if (lane_r == 2'd3) begin
              wr_r   <= 1'b1;
              addr_r <= {{(DATA_WIDTH-18){1'b0}}, cnt_r, 2'b00};
              data_r <= {word_r, bus.ByteIn};
              cnt_r  <= cnt_r + 16'd1;
              lane_r <= 2'd0;
            end else begin
              word_r <= {word_r[15:0], bus.ByteIn};
              lane_r <= lane_r + 2'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.ByteReady    = ready_r;
  assign bus.MemWrite     = wr_r;
  assign bus.MemAddress   = addr_r;
  assign bus.MemWriteData = data_r;
  assign CpuHold          = hold_r;
  assign Done             = done_r;
  assign Error            = error_r;
endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader with hand-computed frames and checksums.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        CpuHold, Done, Error;
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  int          wr_base;
  logic [31:0] img [0:3];
  logic [31:0] mem_model [0:31];

  program_loader_if #(.DATA_WIDTH(32)) bus ();

  program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .bus     (bus),
    .CpuHold (CpuHold),
    .Done    (Done),
    .Error   (Error)
  );

  always #5 clk = ~clk;

  // Program memory stand-in: captures every write strobe.
  always @(negedge clk) begin
    if (bus.MemWrite) begin
      wr_count++;
      mem_model[bus.MemAddress[6:2]] = bus.MemWriteData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_session();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    while (!bus.ByteReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_byte", 32'(bus.ByteReady), 32'd1);
    @(negedge clk);
    bus.ByteValid = 1'b0;
  endtask

  task automatic load(input logic [15:0] n, input logic [7:0] cks, input bit gap);
    logic [31:0] word;
    start_session();
    check("hold_on_start", 32'(CpuHold), 32'd1);
    check("done_cleared", 32'(Done), 32'd0);
    check("error_cleared", 32'(Error), 32'd0);
    send(n[15:8]);
    send(n[7:0]);
    for (int w = 0; w < int'(n); w++) begin
      word = img[w];
      for (int b = 0; b < 4; b++) begin
        send(word[31-8*b -: 8]);
        if (b == 3) begin
          check("wr_strobe", 32'(bus.MemWrite), 32'd1);
          check("wr_addr", bus.MemAddress, 32'(4*w));
          check("wr_data", bus.MemWriteData, word);
        end else begin
          check("no_strobe", 32'(bus.MemWrite), 32'd0);
        end
        if (gap) @(negedge clk);
      end
    end
    send(cks);
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    bus.ByteIn = 8'h00;
    bus.ByteValid = 1'b0;
    for (int i = 0; i < 32; i++) mem_model[i] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(bus.ByteReady), 32'd0);
    check("rst_wr", 32'(bus.MemWrite), 32'd0);
    check("rst_hold", 32'(CpuHold), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_addr", bus.MemAddress, 32'd0);
    check("rst_data", bus.MemWriteData, 32'd0);

    // Valid bytes without a session are ignored
    bus.ByteIn = 8'hAA;
    bus.ByteValid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.ByteReady), 32'd0);
    check("idle_hold", 32'(CpuHold), 32'd0);
    check("idle_writes", 32'(wr_count), 32'd0);
    bus.ByteValid = 1'b0;

    // Single word, good checksum 0x2C
    img[0] = 32'h2008_0005;
    wr_base = wr_count;
    load(16'd1, 8'h2C, 1'b0);
    check("t1_done", 32'(Done), 32'd1);
    check("t1_error", 32'(Error), 32'd0);
    check("t1_hold", 32'(CpuHold), 32'd0);
    check("t1_ready", 32'(bus.ByteReady), 32'd0);
    check("t1_writes", 32'(wr_count - wr_base), 32'd1);
    check("t1_mem0", mem_model[0], 32'h2008_0005);
    check("t1_addr_held", bus.MemAddress, 32'd0);
    check("t1_data_held", bus.MemWriteData, 32'h2008_0005);

    // Same frame, bad checksum 0x2D
    wr_base = wr_count;
    load(16'd1, 8'h2D, 1'b0);
    check("t2_error", 32'(Error), 32'd1);
    check("t2_done", 32'(Done), 32'd0);
    check("t2_hold", 32'(CpuHold), 32'd1);
    check("t2_writes", 32'(wr_count - wr_base), 32'd1);

    // Three words with a bubble after every byte; checksum 0xCF
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    img[2] = 32'h99AA_BBCC;
    wr_base = wr_count;
    load(16'd3, 8'hCF, 1'b1);
    check("t3_done", 32'(Done), 32'd1);
    check("t3_error", 32'(Error), 32'd0);
    check("t3_writes", 32'(wr_count - wr_base), 32'd3);
    check("t3_mem2", mem_model[2], 32'h99AA_BBCC);
    check("t3_mem3_untouched", mem_model[3], 32'hFFFF_FFFF);

    // Oversize length 33
    wr_base = wr_count;
    start_session();
    send(8'h00);
    send(8'h21);
    check("t4_error", 32'(Error), 32'd1);
    check("t4_ready", 32'(bus.ByteReady), 32'd0);
    check("t4_hold", 32'(CpuHold), 32'd1);
    check("t4_done", 32'(Done), 32'd0);
    bus.ByteValid = 1'b1;
    repeat (4) @(negedge clk);
    bus.ByteValid = 1'b0;
    check("t4_writes", 32'(wr_count - wr_base), 32'd0);

    // Empty frame
    wr_base = wr_count;
    load(16'd0, 8'h00, 1'b0);
    check("t5_done", 32'(Done), 32'd1);
    check("t5_writes", 32'(wr_count - wr_base), 32'd0);

    // Reset after six data bytes of a two-word frame
    wr_base = wr_count;
    start_session();
    send(8'h00); send(8'h02);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    send(8'h01); send(8'h02);
    bus.ByteIn = 8'h03;
    bus.ByteValid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.ByteValid = 1'b0;
    check("t6_ready", 32'(bus.ByteReady), 32'd0);
    check("t6_wr", 32'(bus.MemWrite), 32'd0);
    check("t6_hold", 32'(CpuHold), 32'd0);
    check("t6_done", 32'(Done), 32'd0);
    check("t6_error", 32'(Error), 32'd0);
    check("t6_addr", bus.MemAddress, 32'd0);
    check("t6_data", bus.MemWriteData, 32'd0);
    check("t6_writes", 32'(wr_count - wr_base), 32'd1);
    check("t6_mem0", mem_model[0], 32'hA1B2_C3D4);
    check("t6_mem1_kept", mem_model[1], 32'h5566_7788);

    // Clean frame after the abort; checksum 0x23
    img[0] = 32'hDEAD_BEEF;
    load(16'd1, 8'h23, 1'b0);
    check("t7_done", 32'(Done), 32'd1);
    check("t7_mem0", mem_model[0], 32'hDEAD_BEEF);

    // Reset and Start together: reset wins
    reset = 1'b1;
    Start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    Start = 1'b0;
    check("t8_ready", 32'(bus.ByteReady), 32'd0);
    check("t8_done", 32'(Done), 32'd0);
    check("t8_hold", 32'(CpuHold), 32'd0);
    @(negedge clk);
    check("t8_still_idle", 32'(bus.ByteReady), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
